// File: rtl/mini_ex_core_pkg.sv
// mini_ex_core_pkg
// Shared types and helpers for the mini_ex_core load/store path.
//   t_mem_func3      : access size/sign encodings carried in func3
//   t_dmem_req       : one data-memory request (store flag, func3, byte address, store data)
//   t_dmem_rsp       : one data-memory response (load result, error flag)
//   dmem_req_err     : legality check shared by the data memory and the writeback stage
//   dmem_load_extend : lane select plus sign/zero extension of a loaded word
//   dmem_store_be    : byte-lane enables for a store
//   dmem_store_lanes : store data replicated onto every lane it could land in
package mini_ex_core_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } t_mem_func3;

  typedef struct packed {
    logic        WrEn;
    logic [2:0]  Func3;
    logic [31:0] Addr;
    logic [31:0] WrData;
  } t_dmem_req;

  typedef struct packed {
    logic [31:0] Data;
    logic        Err;
  } t_dmem_rsp;

  // BU/HU only exist as loads; 011/110/111 are never legal.
  function automatic logic dmem_func3_ok(input logic wr_en, input logic [2:0] func3);
    case (func3)
      MEM_B, MEM_H, MEM_W: return 1'b1;
      MEM_BU, MEM_HU:      return !wr_en;
      default:             return 1'b0;
    endcase
  endfunction

  // Checks run in priority order: func3, alignment, range. Any hit means the
  // request has no memory side effect and answers with Err=1, Data=0.
  function automatic logic dmem_req_err(input t_dmem_req req, input logic [31:0] depth_words);
    if (!dmem_func3_ok(req.WrEn, req.Func3)) return 1'b1;
    if ((req.Func3 == MEM_H || req.Func3 == MEM_HU) && req.Addr[0]) return 1'b1;
    if (req.Func3 == MEM_W && req.Addr[1:0] != 2'b00) return 1'b1;
    if ({2'b00, req.Addr[31:2]} >= depth_words) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] dmem_load_extend(input logic [2:0]  func3,
                                                   input logic [1:0]  off,
                                                   input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = word[{off[1], 4'b0000} +: 16];
    case (func3)
      MEM_B:   return {{24{byte_v[7]}}, byte_v};
      MEM_H:   return {{16{half_v[15]}}, half_v};
      MEM_BU:  return {24'h000000, byte_v};
      MEM_HU:  return {16'h0000, half_v};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] dmem_store_be(input logic [2:0] func3, input logic [1:0] off);
    case (func3)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return off[1] ? 4'b1100 : 4'b0011;
      MEM_W:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicating the narrow data lets the byte enables alone pick the lane.
  function automatic logic [31:0] dmem_store_lanes(input logic [2:0] func3, input logic [31:0] data);
    case (func3)
      MEM_B:   return {4{data[7:0]}};
      MEM_H:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mini_ex_core_rsp_fifo.sv
// mini_ex_core_rsp_fifo
// First-word-fall-through buffer of data-memory responses.
//   Clk, Rst  : clock and synchronous active-high reset (empties the buffer)
//   push      : write push_data at the rising edge (ignored when full)
//   push_data : response to store
//   pop       : drop the head entry at the rising edge (ignored when empty)
//   head      : oldest entry, valid whenever empty is low
//   full      : DEPTH entries held
//   empty     : no entries held
module mini_ex_core_rsp_fifo
  import mini_ex_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      Clk,
  input  logic      Rst,
  input  logic      push,
  input  t_dmem_rsp push_data,
  input  logic      pop,
  output t_dmem_rsp head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  t_dmem_rsp        slots_q [DEPTH];
  t_dmem_rsp        slots_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = slots_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    slots_d  = slots_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      slots_d[wr_ptr_q] = push_data;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry contents need no reset; only the pointers define what is valid.
  always_ff @(posedge Clk) begin
    slots_q <= slots_d;
  end

endmodule

// File: rtl/mini_ex_core_dmem.sv
// mini_ex_core_dmem
// Data-memory responder for the mini_ex_core load/store path. Requests are
// accepted one per cycle, the word array is read/written at the accept edge,
// and one response per request leaves in order after RD_LATENCY cycles.
//   Clk, Rst   : clock and synchronous active-high reset
//   ReqValid   : request present          ReqReady  : request can be taken
//   ReqWrEn    : 1 store / 0 load         ReqFunc3  : access size and sign
//   ReqAddr    : byte address             ReqWrData : store data, LSB-aligned
//   RspValid   : response present         RspReady  : consumer takes it
//   RspData    : extended load result     RspErr    : request was illegal
module mini_ex_core_dmem
  import mini_ex_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY      = 2,
  parameter int unsigned RSP_FIFO_DEPTH  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrEn,
  input  logic [2:0]            ReqFunc3,
  input  logic [DATA_WIDTH-1:0] ReqAddr,
  input  logic [DATA_WIDTH-1:0] ReqWrData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspErr
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

  t_dmem_req        req;
  t_dmem_rsp        new_rsp;
  t_dmem_rsp        pipe_rsp;
  t_dmem_rsp        fifo_head;
  t_dmem_rsp        last_rsp_q, last_rsp_d;
  logic             req_err;
  logic             accept;
  logic             pop;
  logic             mem_we;
  logic             pipe_push;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [3:0]       store_be;
  logic [31:0]      store_lanes;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;

  // Word array; deliberately outside reset so completed stores survive Rst.
  logic [31:0] mem_array [MEM_DEPTH_WORDS];

  assign req = '{WrEn: ReqWrEn, Func3: ReqFunc3, Addr: ReqAddr, WrData: ReqWrData};

  // Outstanding covers pipeline plus buffer, so bounding it by the buffer
  // depth is what keeps the pipeline from ever overrunning the buffer.
  assign ReqReady = !Rst && (outstanding_q < CNT_W'(RSP_FIFO_DEPTH));
  assign accept   = ReqValid && ReqReady;
  assign pop      = !fifo_empty && RspReady;

  assign word_idx    = req.Addr[2 +: IDX_W];
  assign rd_word     = mem_array[word_idx];
  assign req_err     = dmem_req_err(req, 32'(MEM_DEPTH_WORDS));
  assign store_be    = dmem_store_be(req.Func3, req.Addr[1:0]);
  assign store_lanes = dmem_store_lanes(req.Func3, req.WrData);
  assign mem_we      = accept && req.WrEn && !req_err;

  // Response for the request on the port this cycle; only captured on accept.
  always_comb begin
    new_rsp = '0;
    if (req_err) begin
      new_rsp.Err = 1'b1;
    end else if (!req.WrEn) begin
      new_rsp.Data = dmem_load_extend(req.Func3, req.Addr[1:0], rd_word);
    end
  end

  // A store written at edge N is visible to the combinational read in cycle
  // N+1, which is what gives back-to-back read-after-write without a bypass.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) begin
          mem_array[word_idx][8*i +: 8] <= store_lanes[8*i +: 8];
        end
      end
    end
  end

  // The buffer push itself costs one cycle of latency, so only RD_LATENCY-1
  // register stages sit between accept and the buffer.
  generate
    if (RD_LATENCY == 1) begin : g_no_pipe
      assign pipe_push = accept;
      assign pipe_rsp  = new_rsp;
    end else begin : g_pipe
      localparam int unsigned STAGES = RD_LATENCY - 1;

      logic      [STAGES-1:0] valid_q, valid_d;
      t_dmem_rsp [STAGES-1:0] rsp_q, rsp_d;

      always_comb begin
        valid_d    = valid_q;
        rsp_d      = rsp_q;
        valid_d[0] = accept;
        rsp_d[0]   = new_rsp;
        for (int k = 1; k < int'(STAGES); k++) begin
          valid_d[k] = valid_q[k-1];
          rsp_d[k]   = rsp_q[k-1];
        end
      end

      always_ff @(posedge Clk) begin
        if (Rst) begin
          valid_q <= '0;
        end else begin
          valid_q <= valid_d;
        end
      end

      always_ff @(posedge Clk) begin
        rsp_q <= rsp_d;
      end

      assign pipe_push = valid_q[STAGES-1];
      assign pipe_rsp  = rsp_q[STAGES-1];
    end
  endgenerate

  // The full guard can never block while outstanding stays bounded; it only
  // keeps the buffer self-protecting.
  assign fifo_push = pipe_push && !fifo_full;

  mini_ex_core_rsp_fifo #(
    .DEPTH(RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push     (fifo_push),
    .push_data(pipe_rsp),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Remember the last response handed out so the data port holds it while
  // the buffer is empty.
  always_comb begin
    last_rsp_d = last_rsp_q;
    if (pop) begin
      last_rsp_d = fifo_head;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      outstanding_q <= '0;
      last_rsp_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      last_rsp_q    <= last_rsp_d;
    end
  end

  always_comb begin
    RspValid = !fifo_empty;
    RspData  = last_rsp_q.Data;
    RspErr   = last_rsp_q.Err;
    if (!fifo_empty) begin
      RspData = fifo_head.Data;
      RspErr  = fifo_head.Err;
    end
  end

endmodule

// File: tb/tb_mini_ex_core_dmem.sv
// tb_mini_ex_core_dmem
// Self-checking bench for mini_ex_core_dmem. A byte-addressed memory model and
// a queue of expected responses (with the cycle each may first appear) predict
// every output; a negedge compare process checks them each cycle, and directed
// scenarios pin the model with hand-computed values.
module tb_mini_ex_core_dmem;

  localparam int LAT    = 2;
  localparam int FDEPTH = 4;
  localparam int DEPTHW = 1024;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wr_en = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wr_data = 32'h0;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  mini_ex_core_dmem #(
    .DATA_WIDTH(32),
    .MEM_DEPTH_WORDS(DEPTHW),
    .RD_LATENCY(LAT),
    .RSP_FIFO_DEPTH(FDEPTH)
  ) dut (
    .Clk      (clk),
    .Rst      (rst),
    .ReqValid (req_valid),
    .ReqReady (req_ready),
    .ReqWrEn  (req_wr_en),
    .ReqFunc3 (req_func3),
    .ReqAddr  (req_addr),
    .ReqWrData(req_wr_data),
    .RspValid (rsp_valid),
    .RspReady (rsp_ready),
    .RspData  (rsp_data),
    .RspErr   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          avail;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mbytes [0:4095];
  logic [31:0] last_data = 32'h0;
  logic        last_err  = 1'b0;
  int          cycle     = 0;
  bit          acc_flag  = 0;
  bit          model_rdy;
  exp_t        model_e;

  function automatic exp_t modelReq(input logic wr, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          size;
    bit          sgn;
    bit          bad_f3;
    logic [31:0] v;
    e.data = 32'h0; e.err = 1'b0; e.avail = 0;
    size = 4; sgn = 0; bad_f3 = 0;
    case (f3)
      3'd0:    begin size = 1; sgn = 1; end
      3'd1:    begin size = 2; sgn = 1; end
      3'd2:    size = 4;
      3'd4:    begin size = 1; bad_f3 = wr; end
      3'd5:    begin size = 2; bad_f3 = wr; end
      default: bad_f3 = 1;
    endcase
    if (bad_f3 || (a % size) != 0 || (a / 4) >= DEPTHW) begin
      e.err = 1'b1;
    end else if (wr) begin
      for (int i = 0; i < size; i++) mbytes[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(mbytes[a + i]) << (8 * i));
      if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFFFFFF << (8 * size));
      e.data = v;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    acc_flag = 0;
    if (rst) begin
      exp_q.delete();
      last_data = 32'h0;
      last_err  = 1'b0;
    end else begin
      model_rdy = exp_q.size() < FDEPTH;
      if (exp_q.size() > 0 && exp_q[0].avail <= cycle && rsp_ready) begin
        last_data = exp_q[0].data;
        last_err  = exp_q[0].err;
        void'(exp_q.pop_front());
      end
      if (req_valid && model_rdy) begin
        model_e       = modelReq(req_wr_en, req_func3, req_addr, req_wr_data);
        model_e.avail = cycle + LAT;
        exp_q.push_back(model_e);
        acc_flag = 1;
      end
    end
    cycle++;
  end

  // ---------------- per-cycle compare ----------------
  logic [32:0] cap_q[$];
  int          acc_cnt = 0;
  bit          exp_v;

  always @(negedge clk) begin
    if (!rst) begin
      exp_v = exp_q.size() > 0 && exp_q[0].avail <= cycle;
      checkOutput("rsp_valid", rsp_valid, exp_v);
      checkOutput("req_ready", req_ready, exp_q.size() < FDEPTH);
      if (exp_v) begin
        checkOutput("rsp_data", rsp_data, exp_q[0].data);
        checkOutput("rsp_err", rsp_err, exp_q[0].err);
      end else begin
        checkOutput("idle_data", rsp_data, last_data);
        checkOutput("idle_err", rsp_err, last_err);
      end
      if (rsp_valid && rsp_ready) cap_q.push_back({rsp_err, rsp_data});
      if (req_valid && req_ready) acc_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1; req_wr_en = wr; req_func3 = f3; req_addr = a; req_wr_data = wd;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc_flag && n < 200);
    if (!acc_flag) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got no accept want accept at addr %h", a);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() > 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic checkCap(input string name, input int idx, input logic [32:0] exp);
    if (idx < cap_q.size()) checkOutput(name, cap_q[idx], exp);
    else begin
      total++; bad++;
      $display("[TB] FAIL %s: got no response want %h", name, exp);
    end
  endtask

  // ---------------- directed + random scenarios ----------------
  bit          rnd_done = 0;
  logic        r_wr;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready_low", req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", req_ready, 1'b1);
    checkOutput("post_rst_valid", rsp_valid, 1'b0);
    checkOutput("post_rst_data", rsp_data, 32'h0);
    checkOutput("post_rst_err", rsp_err, 1'b0);
    @(posedge clk); #1;

    // SW then LW back to back: store response at N+2, load response at N+3.
    rsp_ready = 1'b1;
    applyStimulus(1'b1, F_W, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, F_W, 32'h10, 32'h0);
    @(negedge clk);
    checkOutput("t1_sw_valid", rsp_valid, 1'b1);
    checkOutput("t1_sw_rsp", {rsp_err, rsp_data}, 33'h0);
    @(negedge clk);
    checkOutput("t1_lw_valid", rsp_valid, 1'b1);
    checkOutput("t1_lw_rsp", {rsp_err, rsp_data}, {1'b0, 32'hDEADBEEF});
    @(negedge clk);
    checkOutput("t1_idle_valid", rsp_valid, 1'b0);
    checkOutput("t1_idle_hold", rsp_data, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Byte store and sign/zero-extended narrow loads.
    cap_q.delete();
    applyStimulus(1'b1, F_W,  32'h10, 32'h0);
    applyStimulus(1'b1, F_B,  32'h11, 32'h80);
    applyStimulus(1'b0, F_B,  32'h11, 32'h0);
    applyStimulus(1'b0, F_BU, 32'h11, 32'h0);
    applyStimulus(1'b0, F_H,  32'h10, 32'h0);
    drain();
    checkOutput("t2_count", cap_q.size(), 5);
    checkCap("t2_sb", 1, 33'h0);
    checkCap("t2_lb", 2, {1'b0, 32'hFFFFFF80});
    checkCap("t2_lbu", 3, {1'b0, 32'h00000080});
    checkCap("t2_lh", 4, {1'b0, 32'hFFFF8000});

    // Illegal requests: misaligned LW/SH, out-of-range LW, store with func3=100.
    cap_q.delete();
    applyStimulus(1'b0, F_W,  32'h12,   32'h0);
    applyStimulus(1'b1, F_H,  32'h13,   32'h0000AAAA);
    applyStimulus(1'b0, F_W,  32'h1000, 32'h0);
    applyStimulus(1'b1, F_BU, 32'h10,   32'hFFFFFFFF);
    applyStimulus(1'b0, F_W,  32'h10,   32'h0);
    drain();
    checkCap("t3_lw_misal", 0, {1'b1, 32'h0});
    checkCap("t3_sh_misal", 1, {1'b1, 32'h0});
    checkCap("t3_lw_range", 2, {1'b1, 32'h0});
    checkCap("t3_st_func3", 3, {1'b1, 32'h0});
    checkCap("t3_mem_kept", 4, {1'b0, 32'h00008000});

    // Backpressure: six loads with RspReady low, only four may be taken.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, F_W, 32'h40 + 4*i, 32'h10000000 + 32'h11*i);
    drain();
    cap_q.delete();
    acc_cnt = 0;
    rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, F_W, 32'h40 + 4*i, 32'h0);
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("t4_full_ready", req_ready, 1'b0);
        checkOutput("t4_accepts", acc_cnt, 4);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    drain();
    checkOutput("t4_count", cap_q.size(), 6);
    for (int i = 0; i < 6; i++) checkCap("t4_order", i, {1'b0, 32'h10000000 + 32'h11*i});

    // Reset with loads in flight: no stale responses, memory retained.
    applyStimulus(1'b1, F_W, 32'h20, 32'h12345678);
    drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, F_W, 32'h20, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_data", rsp_data, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    cap_q.delete();
    applyStimulus(1'b0, F_W, 32'h20, 32'h0);
    drain();
    checkOutput("t5_count", cap_q.size(), 1);
    checkCap("t5_retained", 0, {1'b0, 32'h12345678});

    // Random legal traffic with random consumer backpressure.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, F_W, 32'h400 + 4*i, $urandom);
    drain();
    cap_q.delete();
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          r_wr = 1'($urandom_range(0, 1));
          case ($urandom_range(0, r_wr ? 2 : 4))
            0:       r_f3 = F_B;
            1:       r_f3 = F_H;
            2:       r_f3 = F_W;
            3:       r_f3 = F_BU;
            default: r_f3 = F_HU;
          endcase
          r_addr = 32'h400 + 4 * $urandom_range(0, 15);
          if (r_f3 == F_B || r_f3 == F_BU) r_addr = r_addr + $urandom_range(0, 3);
          else if (r_f3 == F_H || r_f3 == F_HU) r_addr = r_addr + 2 * $urandom_range(0, 1);
          applyStimulus(r_wr, r_f3, r_addr, $urandom);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    checkOutput("t6_count", cap_q.size(), 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
